// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose : Groups the requester-side and memory-side signals of the
//           mem_port_arbiter into one bundle.
//
// Signals :
//   Fetch requester  : i_valid, i_addr           (to arbiter)
//                      i_ready                   (from arbiter)
//   Data requester   : d_valid, d_addr, d_wdata,
//                      d_wstrb                   (to arbiter; d_wstrb == 0 means read)
//                      d_ready                   (from arbiter)
//   Shared read data : rdata                     (from arbiter; valid only with a ready)
//   Memory side      : mem_valid, mem_addr, mem_wdata, mem_wstrb (from arbiter)
//                      mem_ready, mem_rdata      (to arbiter)
//
// Modports :
//   slave  - the arbiter's view of the bundle
//   master - the environment's view (requesters and memory model)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   // fetch requester
   logic                  i_valid;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_ready;

   // data requester
   logic                  d_valid;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic [STRB_WIDTH-1:0] d_wstrb;
   logic                  d_ready;

   // shared read data
   logic [DATA_WIDTH-1:0] rdata;

   // memory side
   logic                  mem_valid;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [STRB_WIDTH-1:0] mem_wstrb;
   logic                  mem_ready;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  i_valid, i_addr,
      input  d_valid, d_addr, d_wdata, d_wstrb,
      input  mem_ready, mem_rdata,
      output i_ready, d_ready, rdata,
      output mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output i_valid, i_addr,
      output d_valid, d_addr, d_wdata, d_wstrb,
      output mem_ready, mem_rdata,
      input  i_ready, d_ready, rdata,
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose : Shares one single-outstanding memory port between an instruction
//           fetch requester and a data (load/store) requester.
//           A three-state FSM (IDLE, GRANT_I, GRANT_D) arbitrates in IDLE,
//           latches the winner's address/data/strobes, and then presents
//           them to memory until mem_ready completes the access. The
//           completion strobe (i_ready or d_ready) is a combinational copy of
//           mem_ready for the granted side, and rdata is mem_rdata passed
//           straight through. Every completion returns to IDLE, so
//           back-to-back accesses always have one idle bubble.
//
// Ports   :
//   clk    - clock, all state updates on the rising edge
//   resetn - synchronous, active-low reset
//   bus    - mem_port_arbiter_if.slave: requester handshakes, shared rdata
//            and the memory-side request/response signals
//
// Parameters :
//   ADDR_WIDTH - address width in bits (must match the interface instance)
//   DATA_WIDTH - data width in bits; strobe width is DATA_WIDTH/8
//
// Configuration macro :
//   MEM_ARB_ROUND_ROBIN_EN - when defined, a simultaneous fetch/data request
//            in IDLE is granted to the side that was NOT served last.
//            When undefined, data always wins a tie (fixed priority);
//            last_grant is still tracked but does not influence arbitration.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   mem_port_arbiter_if.slave     bus
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   state_t                state_reg,      state_next;
   logic [ADDR_WIDTH-1:0] addr_reg,       addr_next;
   logic [DATA_WIDTH-1:0] wdata_reg,      wdata_next;
   logic [STRB_WIDTH-1:0] wstrb_reg,      wstrb_next;
   logic                  last_grant_reg, last_grant_next;  // 0 = fetch, 1 = data

   logic                  pick_d;
   logic                  pick_i;
   logic                  i_ready_c;
   logic                  d_ready_c;

   // -------------------------------------------------------------------------
   // Arbitration decision, only consumed while in IDLE.
   // -------------------------------------------------------------------------
   always_comb begin
      pick_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // On a tie, data wins only if fetch was the side served last.
      pick_d = bus.d_valid & (~bus.i_valid | ~last_grant_reg);
`else
      // Fixed priority: data always wins a tie.
      pick_d = bus.d_valid;
`endif
      pick_i = bus.i_valid & ~pick_d;
   end

   // -------------------------------------------------------------------------
   // State and request-copy registers.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         wstrb_reg      <= '0;
         last_grant_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         wstrb_reg      <= wstrb_next;
         last_grant_reg <= last_grant_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and completion logic.
   // The request copies are loaded only when leaving IDLE, so requesters
   // are free to drop valid or change addr/data while their access is in
   // flight.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      wstrb_next      = wstrb_reg;
      last_grant_next = last_grant_reg;
      i_ready_c       = 1'b0;
      d_ready_c       = 1'b0;

      case (state_reg)
         IDLE: begin
            // mem_ready is deliberately not looked at here.
            if (pick_d) begin
               state_next = GRANT_D;
               addr_next  = bus.d_addr;
               wdata_next = bus.d_wdata;
               wstrb_next = bus.d_wstrb;
            end else if (pick_i) begin
               // A fetch is always a read: zero data and strobes.
               state_next = GRANT_I;
               addr_next  = bus.i_addr;
               wdata_next = '0;
               wstrb_next = '0;
            end
         end

         GRANT_I: begin
            if (bus.mem_ready) begin
               i_ready_c       = 1'b1;
               last_grant_next = 1'b0;
               state_next      = IDLE;
            end
         end

         GRANT_D: begin
            if (bus.mem_ready) begin
               d_ready_c       = 1'b1;
               last_grant_next = 1'b1;
               state_next      = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs. Ready strobes are masked by resetn so that a reset landing
   // mid-grant can never produce a completion pulse, even if memory happens
   // to answer in that same cycle.
   // -------------------------------------------------------------------------
   assign bus.i_ready   = i_ready_c & resetn;
   assign bus.d_ready   = d_ready_c & resetn;
   assign bus.rdata     = bus.mem_rdata;

   assign bus.mem_valid = (state_reg == GRANT_I) || (state_reg == GRANT_D);
   assign bus.mem_addr  = addr_reg;
   assign bus.mem_wdata = wdata_reg;
   assign bus.mem_wstrb = wstrb_reg;

   // The two completion strobes are mutually exclusive by construction.
   a_ready_onehot: assert property (@(posedge clk) !(bus.i_ready && bus.d_ready));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A table of per-cycle records holds the
// inputs for one clock cycle and the outputs expected in that same cycle
// (sampled on the falling edge). A few hand-written sequences follow for
// reset state and a long memory wait with a bounded completion search.
// Expectations for the contention sequence depend on whether
// MEM_ARB_ROUND_ROBIN_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic clk;
   logic resetn;

   mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        iv;
      logic [31:0] ia;
      logic        dv;
      logic [31:0] da;
      logic [31:0] dw;
      logic [3:0]  ds;
      logic        mr;
      logic [31:0] md;
      logic        e_mv;
      logic [31:0] e_ma;
      logic [31:0] e_mw;
      logic [3:0]  e_ms;
      logic        e_ir;
      logic        e_dr;
   } vec_t;

   // Second and fourth grant of the contention sequence: fetch under
   // round-robin, data under fixed priority.
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam logic [31:0] G2_A  = 32'h0000_0500;
   localparam logic [31:0] G2_W  = 32'h0000_0000;
   localparam logic [3:0]  G2_S  = 4'h0;
   localparam logic        G2_IR = 1'b1;
   localparam logic        G2_DR = 1'b0;
`else
   localparam logic [31:0] G2_A  = 32'h0000_0600;
   localparam logic [31:0] G2_W  = 32'hA5A5_A5A5;
   localparam logic [3:0]  G2_S  = 4'h1;
   localparam logic        G2_IR = 1'b0;
   localparam logic        G2_DR = 1'b1;
`endif

   int n_vec;
   int n_bad;

   task automatic drive(input vec_t v);
      resetn        = v.rst_n;
      bus.i_valid   = v.iv;
      bus.i_addr    = v.ia;
      bus.d_valid   = v.dv;
      bus.d_addr    = v.da;
      bus.d_wdata   = v.dw;
      bus.d_wstrb   = v.ds;
      bus.mem_ready = v.mr;
      bus.mem_rdata = v.md;
   endtask

   task automatic check(input string name, input vec_t v);
      n_vec++;
      if (bus.mem_valid !== v.e_mv || bus.mem_addr !== v.e_ma || bus.mem_wdata !== v.e_mw ||
          bus.mem_wstrb !== v.e_ms || bus.i_ready !== v.e_ir || bus.d_ready !== v.e_dr ||
          bus.rdata !== v.md) begin
         n_bad++;
         $display("FAIL %s: got mv=%0b ma=%h mw=%h ms=%h ir=%0b dr=%0b rd=%h, want mv=%0b ma=%h mw=%h ms=%h ir=%0b dr=%0b rd=%h",
                  name, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
                  bus.i_ready, bus.d_ready, bus.rdata,
                  v.e_mv, v.e_ma, v.e_mw, v.e_ms, v.e_ir, v.e_dr, v.md);
      end else begin
         $display("vec %s: mv=%0b ma=%h mw=%h ms=%h ir=%0b dr=%0b rd=%h",
                  name, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
                  bus.i_ready, bus.d_ready, bus.rdata);
      end
   endtask

   initial begin
      vec_t tbl[$];
      vec_t v;
      int   lat;
      int   stable_bad;

      n_vec = 0;
      n_bad = 0;

      //           rst iv  ia            dv  da            dw            ds    mr  md              mv  ma            mw            ms    ir  dr
      // Single fetch: arbitration cycle, then memory answers at once.
      tbl.push_back('{1, 1, 32'h100,     0, 32'h0,     32'h0,        4'h0, 1, 32'h1111_1111, 0, 32'h0,     32'h0,        4'h0, 0, 0});
      tbl.push_back('{1, 0, 32'h100,     0, 32'h0,     32'h0,        4'h0, 1, 32'hCAFE_F00D, 1, 32'h100,   32'h0,        4'h0, 1, 0});
      tbl.push_back('{1, 0, 32'h0,       0, 32'h0,     32'h0,        4'h0, 0, 32'h2222_2222, 0, 32'h100,   32'h0,        4'h0, 0, 0});
      // Store with three wait cycles; memory signals stable for four cycles.
      tbl.push_back('{1, 0, 32'h0,       1, 32'h2000,  32'hDEADBEEF, 4'hF, 0, 32'h3333_3333, 0, 32'h100,   32'h0,        4'h0, 0, 0});
      tbl.push_back('{1, 0, 32'h0,       1, 32'h2000,  32'hDEADBEEF, 4'hF, 0, 32'h4444_4444, 1, 32'h2000,  32'hDEADBEEF, 4'hF, 0, 0});
      tbl.push_back('{1, 0, 32'h0,       1, 32'h2000,  32'hDEADBEEF, 4'hF, 0, 32'h5555_5555, 1, 32'h2000,  32'hDEADBEEF, 4'hF, 0, 0});
      tbl.push_back('{1, 0, 32'h0,       1, 32'h2000,  32'hDEADBEEF, 4'hF, 0, 32'h6666_6666, 1, 32'h2000,  32'hDEADBEEF, 4'hF, 0, 0});
      tbl.push_back('{1, 0, 32'h0,       0, 32'h2000,  32'hDEADBEEF, 4'hF, 1, 32'h8765_4321, 1, 32'h2000,  32'hDEADBEEF, 4'hF, 0, 1});
      // mem_ready in IDLE is ignored.
      tbl.push_back('{1, 0, 32'h0,       0, 32'h0,     32'h0,        4'h0, 1, 32'h7777_7777, 0, 32'h2000,  32'hDEADBEEF, 4'hF, 0, 0});
      // Data requester drops valid and zeroes its address during the grant.
      tbl.push_back('{1, 0, 32'h0,       1, 32'h3000,  32'h12345678, 4'h3, 0, 32'h0,        0, 32'h2000,  32'hDEADBEEF, 4'hF, 0, 0});
      tbl.push_back('{1, 0, 32'h0,       0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        1, 32'h3000,  32'h12345678, 4'h3, 0, 0});
      tbl.push_back('{1, 0, 32'h0,       0, 32'h0,     32'h0,        4'h0, 1, 32'hABCD_0123, 1, 32'h3000,  32'h12345678, 4'h3, 0, 1});
      tbl.push_back('{1, 0, 32'h0,       0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        0, 32'h3000,  32'h12345678, 4'h3, 0, 0});
      // Fetch ignores idle store data; held fetch gets an idle bubble.
      tbl.push_back('{1, 1, 32'h400,     0, 32'h0,     32'hFFFFFFFF, 4'hF, 0, 32'h0,        0, 32'h3000,  32'h12345678, 4'h3, 0, 0});
      tbl.push_back('{1, 1, 32'h400,     0, 32'h0,     32'hFFFFFFFF, 4'hF, 1, 32'h1357_9BDF, 1, 32'h400,   32'h0,        4'h0, 1, 0});
      tbl.push_back('{1, 1, 32'h404,     0, 32'h0,     32'h0,        4'h0, 1, 32'h0,        0, 32'h400,   32'h0,        4'h0, 0, 0});
      tbl.push_back('{1, 0, 32'h404,     0, 32'h0,     32'h0,        4'h0, 1, 32'h2468_ACE0, 1, 32'h404,   32'h0,        4'h0, 1, 0});
      tbl.push_back('{1, 0, 32'h0,       0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        0, 32'h404,   32'h0,        4'h0, 0, 0});
      // Both requesters held for four transactions (last served: fetch).
      tbl.push_back('{1, 1, 32'h500,     1, 32'h600,   32'hA5A5A5A5, 4'h1, 1, 32'h0,        0, 32'h404,   32'h0,        4'h0, 0, 0});
      tbl.push_back('{1, 1, 32'h500,     1, 32'h600,   32'hA5A5A5A5, 4'h1, 1, 32'hF0F0_F0F0, 1, 32'h600,   32'hA5A5A5A5, 4'h1, 0, 1});
      tbl.push_back('{1, 1, 32'h500,     1, 32'h600,   32'hA5A5A5A5, 4'h1, 1, 32'h0,        0, 32'h600,   32'hA5A5A5A5, 4'h1, 0, 0});
      tbl.push_back('{1, 1, 32'h500,     1, 32'h600,   32'hA5A5A5A5, 4'h1, 1, 32'h0F0F_0F0F, 1, G2_A,      G2_W,         G2_S, G2_IR, G2_DR});
      tbl.push_back('{1, 1, 32'h500,     1, 32'h600,   32'hA5A5A5A5, 4'h1, 1, 32'h0,        0, G2_A,      G2_W,         G2_S, 0, 0});
      tbl.push_back('{1, 1, 32'h500,     1, 32'h600,   32'hA5A5A5A5, 4'h1, 1, 32'h1234_0000, 1, 32'h600,   32'hA5A5A5A5, 4'h1, 0, 1});
      tbl.push_back('{1, 1, 32'h500,     1, 32'h600,   32'hA5A5A5A5, 4'h1, 1, 32'h0,        0, 32'h600,   32'hA5A5A5A5, 4'h1, 0, 0});
      tbl.push_back('{1, 0, 32'h500,     0, 32'h600,   32'hA5A5A5A5, 4'h1, 1, 32'h5A5A_5A5A, 1, G2_A,      G2_W,         G2_S, G2_IR, G2_DR});
      tbl.push_back('{1, 0, 32'h0,       0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        0, G2_A,      G2_W,         G2_S, 0, 0});
      // Reset during GRANT_D with memory stalled aborts without a ready.
      tbl.push_back('{1, 0, 32'h0,       1, 32'h700,   32'h0BADF00D, 4'hC, 0, 32'h0,        0, G2_A,      G2_W,         G2_S, 0, 0});
      tbl.push_back('{0, 0, 32'h0,       0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        1, 32'h700,   32'h0BADF00D, 4'hC, 0, 0});
      tbl.push_back('{1, 1, 32'h800,     0, 32'h0,     32'h0,        4'h0, 1, 32'h0,        0, 32'h0,     32'h0,        4'h0, 0, 0});
      tbl.push_back('{1, 0, 32'h800,     0, 32'h0,     32'h0,        4'h0, 1, 32'h3141_5926, 1, 32'h800,   32'h0,        4'h0, 1, 0});
      // Tie right after a fetch completion: data wins in both builds.
      tbl.push_back('{1, 1, 32'h900,     1, 32'hA00,   32'h01020304, 4'h2, 0, 32'h0,        0, 32'h800,   32'h0,        4'h0, 0, 0});
      tbl.push_back('{1, 1, 32'h900,     1, 32'hA00,   32'h01020304, 4'h2, 1, 32'h0A0B_0C0D, 1, 32'hA00,   32'h01020304, 4'h2, 0, 1});
      tbl.push_back('{1, 0, 32'h0,       0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        0, 32'hA00,   32'h01020304, 4'h2, 0, 0});

      // Reset state: hold reset for two edges, then check everything idle.
      v = '{0, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hFEED_0000, 0, 32'h0, 32'h0, 4'h0, 0, 0};
      drive(v);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset", v);
      @(posedge clk);
      #1;

      // Table: drive just after the rising edge, compare on the falling edge.
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         @(negedge clk);
         check($sformatf("t%0d", i), tbl[i]);
         @(posedge clk);
         #1;
      end

      // Long memory wait: store issued at cycle 0, memory answers at cycle 6.
      lat        = -1;
      stable_bad = 0;
      v = '{1, 0, 32'h0, 1, 32'hB00, 32'h55AA55AA, 4'hF, 0, 32'h0, 0, 32'h0, 32'h0, 4'h0, 0, 0};
      drive(v);
      for (int cyc = 0; cyc < 20 && lat < 0; cyc++) begin
         @(negedge clk);
         if (cyc >= 1 && (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'hB00 ||
                          bus.mem_wdata !== 32'h55AA55AA || bus.i_ready !== 1'b0))
            stable_bad++;
         if (bus.d_ready === 1'b1) lat = cyc;
         @(posedge clk);
         #1;
         bus.d_valid   = 1'b0;
         bus.mem_ready = (cyc + 1 == 6);
      end
      n_vec++;
      if (lat != 6) begin
         n_bad++;
         $display("FAIL wait_latency: got %0d cycles, want 6 (-1 means no d_ready within budget)", lat);
      end else begin
         $display("vec wait_latency: d_ready after %0d cycles", lat);
      end
      n_vec++;
      if (stable_bad != 0) begin
         n_bad++;
         $display("FAIL wait_stable: got %0d unstable grant cycles, want 0", stable_bad);
      end else begin
         $display("vec wait_stable: request held stable during wait");
      end
      @(negedge clk);
      n_vec++;
      if (bus.d_ready !== 1'b0 || bus.mem_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL wait_pulse: got d_ready=%0b mem_valid=%0b after completion, want 0 0",
                  bus.d_ready, bus.mem_valid);
      end else begin
         $display("vec wait_pulse: single-cycle d_ready, back in idle");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, memory address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, memory data width in bits; the strobe width is DATA_WIDTH/8.
REQ-003 The block SHALL have port clk, input, 1, clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1, reset; it SHALL be synchronous and active-low.
REQ-005 The block SHALL have port i_valid, input, 1, instruction-fetch request.
REQ-006 The block SHALL have port i_addr, input, ADDR_WIDTH, fetch address.
REQ-007 The block SHALL have port i_ready, output, 1, fetch completion strobe.
REQ-008 The block SHALL have port d_valid, input, 1, data-access request.
REQ-009 The block SHALL have port d_addr, input, ADDR_WIDTH, data address.
REQ-010 The block SHALL have port d_wdata, input, DATA_WIDTH, store data.
REQ-011 The block SHALL have port d_wstrb, input, DATA_WIDTH/8, byte write strobes; all-zero means read.
REQ-012 The block SHALL have port d_ready, output, 1, data completion strobe.
REQ-013 The block SHALL have port rdata, output, DATA_WIDTH, shared read data, valid only while i_ready or d_ready is high.
REQ-014 The block SHALL have memory-side ports mem_valid (output, 1), mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH), mem_wstrb (output, DATA_WIDTH/8), mem_ready (input, 1) and mem_rdata (input, DATA_WIDTH).

Function
REQ-015 The block SHALL implement a state machine with states IDLE, GRANT_I and GRANT_D.
REQ-016 In IDLE with only i_valid high, the next state SHALL be GRANT_I; with only d_valid high, GRANT_D; with neither, IDLE.
REQ-017 When leaving IDLE, the block SHALL register the winner's addr/wdata/wstrb; fetch grants SHALL register wstrb=0 and wdata=0.
REQ-018 mem_valid SHALL be high exactly while the state is GRANT_I or GRANT_D, and mem_addr/mem_wdata/mem_wstrb SHALL come only from the registered copies.
REQ-019 In a GRANT state with mem_ready high, the granted requester's ready SHALL be high in the same cycle, combinationally, the other ready SHALL stay low, and the next state SHALL be IDLE.
REQ-020 rdata SHALL equal mem_rdata combinationally.
REQ-021 Minimum latency from valid to ready SHALL be 2 cycles (1 arbitration cycle + 1 memory cycle with mem_ready=1); back-to-back transactions SHALL include one IDLE bubble.
REQ-022 A requester dropping valid or changing addr/wdata during its grant SHALL NOT affect the transaction in flight; the transaction SHALL complete and ready SHALL still pulse.
REQ-023 A register last_grant (0=fetch, 1=data) SHALL update to the served requester on each completion.
REQ-024 i_ready and d_ready SHALL never be high in the same cycle.
REQ-025 mem_ready high while in IDLE SHALL be ignored.

Reset
REQ-026 With resetn low at a clock edge, the state SHALL become IDLE and last_grant SHALL become 0; mem_valid, i_ready and d_ready SHALL be 0 from the following cycle; the registered addr/wdata/wstrb SHALL become 0.
REQ-027 Reset asserted mid-grant SHALL abort the transaction without a ready pulse.

Configuration
REQ-028 With macro MEM_ARB_ROUND_ROBIN_EN defined, a simultaneous i_valid/d_valid in IDLE SHALL grant the requester not equal to last_grant.
REQ-029 Without MEM_ARB_ROUND_ROBIN_EN, a simultaneous request SHALL always grant data (fixed priority), and last_grant SHALL still be maintained but SHALL not affect arbitration.

Verification
REQ-030 Single fetch: i_valid=1, i_addr=0x100, mem_ready=1 at cycle 1 -> mem_valid=1 with mem_addr=0x100 and wstrb=0 at cycle 1, and i_ready=1 with rdata=mem_rdata at cycle 1.
REQ-031 Store: d_valid=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF, mem_ready delayed 3 cycles -> mem signals stable for 4 cycles, d_ready=1 for one cycle only.
REQ-032 Simultaneous i_valid and d_valid held for 4 transactions -> grant order D,I,D,I with the round-robin macro defined; D,D,D,D without it.
REQ-033 d_valid dropped and d_addr changed to 0x0 one cycle after grant -> mem_addr stays at the original value and d_ready still pulses.
REQ-034 resetn=0 during GRANT_D with mem_ready=0 -> mem_valid=0 and d_ready=0 the next cycle; after release with i_valid=1 -> normal GRANT_I.
